spi_master_multi: RTL

Parametrised full-duplex SPI master, the next generation of `spi_master`. It drives up to NUM_CS slaves over one shared `sclk`/`mosi`/`miso` bus. SPI mode (CPOL/CPHA), target chip select and frame length (1..MAX_WIDTH bits) are chosen per transaction rather than fixed at elaboration. It sits between user logic on `user_clk` and the board SPI pins, and transmits and receives on every transfer.

---
 rtl/spi_master_multi.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master, mode/cs/len per transfer; `SPI_MASTER_MULTI_LOOPBACK_EN samples mosi instead of miso.
// Latency: o_rd_evt HALF*(2*len+2) cycles after acceptance, o_ready back HALF*(2*len+3) after acceptance.
// Backpressure: o_ready low while busy; requests arriving then are dropped, never queued.
module spi_master_multi #(
  parameter logic [31:0] USER_CLK_RATE   = 32'd100_000_000,
  parameter logic [31:0] SPI_CLK_RATE    = 32'd2_500_000,
  parameter logic        MCS_VALID_LEVEL = 1'b0,
  parameter logic        DATA_ENDIAN     = 1'b1,
  parameter int          MAX_WIDTH       = 32,
  parameter int          NUM_CS          = 4,
  parameter int          CS_W            = 2,
  parameter int          LEN_W           = 6
) (
  input  logic                 user_clk,
  input  logic                 user_rst,
  input  logic                 i_xfer_evt,
  input  logic [CS_W-1:0]      i_cs_sel,
  input  logic [1:0]           i_mode,
  input  logic [LEN_W-1:0]     i_len,
  input  logic [MAX_WIDTH-1:0] i_wr_data,
  output logic                 o_ready,
  output logic                 o_rd_evt,
  output logic [MAX_WIDTH-1:0] o_rd_data,
  output logic [NUM_CS-1:0]    mcs,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso
);

  localparam int HALF = int'(USER_CLK_RATE / (32'd2 * SPI_CLK_RATE));
  localparam int HC_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [LEN_W:0] HP_ONE = 1;
  localparam logic [NUM_CS-1:0] MCS_IDLE = {NUM_CS{~MCS_VALID_LEVEL}};

  if (HALF < 2) begin : g_half_chk
    $error("spi_master_multi: USER_CLK_RATE/(2*SPI_CLK_RATE) must be >= 2");
  end
  if (CS_W < $clog2(NUM_CS)) begin : g_cs_chk
    $error("spi_master_multi: CS_W too narrow for NUM_CS");
  end
  if (LEN_W < $clog2(MAX_WIDTH + 1) || MAX_WIDTH < 2) begin : g_len_chk
    $error("spi_master_multi: LEN_W/MAX_WIDTH out of range");
  end

  typedef struct packed {
    logic [CS_W-1:0]      cs;
    logic [1:0]           mode;
    logic [LEN_W-1:0]     len;
    logic [MAX_WIDTH-1:0] dat;
  } req_t;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t               state, state_nxt;
  req_t                 req;
  logic                 req_ok, accept;
  logic [HC_W-1:0]      hcnt;
  logic                 tick;
  logic [LEN_W:0]       hp, hp_last, edge_idx;
  logic [LEN_W-1:0]     len_q;
  logic [1:0]           mode_q;
  logic [MAX_WIDTH-1:0] tx_sh, tx_init, tx_adv, rx_sh, rx_nxt;
  logic [NUM_CS-1:0]    mcs_sel;
  logic                 toggle, leading, do_sample, do_adv, done, samp;

  function automatic logic head(input logic [MAX_WIDTH-1:0] v);
    return DATA_ENDIAN ? v[MAX_WIDTH-1] : v[0];
  endfunction

`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
  assign samp = mosi;
`else
  assign samp = miso;
`endif

  // Zero length or an absent slave never leaves IDLE, so the bus stays untouched.
  always_comb begin
    req.cs   = i_cs_sel;
    req.mode = i_mode;
    req.len  = (32'(i_len) > MAX_WIDTH) ? LEN_W'(MAX_WIDTH) : i_len;
    req.dat  = i_wr_data;
    req_ok   = (i_len != '0) && (32'(i_cs_sel) < NUM_CS);
    accept   = (state == IDLE) && i_xfer_evt && req_ok;
    for (int i = 0; i < NUM_CS; i++)
      mcs_sel[i] = (32'(req.cs) == i) ? MCS_VALID_LEVEL : ~MCS_VALID_LEVEL;
    tx_init  = DATA_ENDIAN ? (req.dat << (MAX_WIDTH - int'(req.len))) : req.dat;
    tx_adv   = DATA_ENDIAN ? (tx_sh << 1) : (tx_sh >> 1);
    rx_nxt   = DATA_ENDIAN ? {rx_sh[MAX_WIDTH-2:0], samp} : {samp, rx_sh[MAX_WIDTH-1:1]};
  end

  assign tick    = (hcnt == HC_W'(HALF - 1));
  assign hp_last = {len_q, 1'b0} - HP_ONE;

  always_ff @(posedge user_clk) begin
    if (user_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   if (tick) state_nxt = SHIFT;
      SHIFT:   if (tick && hp == hp_last) state_nxt = HOLD;
      HOLD:    if (tick) state_nxt = GAP;
      GAP:     if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Edge h starts half-period h: even h is a leading edge, odd h a trailing edge.
  always_comb begin
    o_ready   = (state == IDLE);
    toggle    = tick && ((state == SETUP) || (state == SHIFT && hp != hp_last));
    edge_idx  = (state == SETUP) ? '0 : hp + HP_ONE;
    leading   = ~edge_idx[0];
    do_sample = toggle && (mode_q[0] ? ~leading : leading);
    do_adv    = toggle && (mode_q[0] ? (leading && edge_idx != '0)
                                     : (~leading && edge_idx != hp_last));
    done      = (state == HOLD) && tick;
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      hcnt      <= '0;
      hp        <= '0;
      len_q     <= '0;
      mode_q    <= 2'b00;
      tx_sh     <= '0;
      rx_sh     <= '0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      mcs       <= MCS_IDLE;
      o_rd_evt  <= 1'b0;
      o_rd_data <= '0;
    end else begin
      o_rd_evt <= 1'b0;
      hcnt     <= (state == IDLE || tick) ? '0 : hcnt + HC_W'(1);
      if (accept) begin
        mode_q <= req.mode;
        len_q  <= req.len;
        tx_sh  <= tx_init;
        mosi   <= head(tx_init);
        sclk   <= req.mode[1];
        mcs    <= mcs_sel;
        rx_sh  <= '0;
        hp     <= '0;
      end
      if (state == SHIFT && tick) hp <= hp + HP_ONE;
      if (toggle) sclk <= ~sclk;
      if (do_adv) begin
        tx_sh <= tx_adv;
        mosi  <= head(tx_adv);
      end
      if (do_sample) rx_sh <= rx_nxt;
      // LSB-first frames fill from the top, so realign to bit 0 on completion.
      if (done) begin
        mcs       <= MCS_IDLE;
        o_rd_evt  <= 1'b1;
        o_rd_data <= DATA_ENDIAN ? rx_sh : (rx_sh >> (MAX_WIDTH - int'(len_q)));
      end
    end
  end

endmodule
